mc_ctrl: RTL and testbench

//  Multi-cycle main controller for the MIPS datapath. It sequences IF/ID/EXE/MEM/WB
//  and generates every datapath control, including EXTSel, which drives the immediate

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_ctrl_if.sv | 32 +++
 rtl/mc_decode.sv | 42 ++++
 rtl/mc_ctrl.sv | 112 +++++++++++
 tb/tb_mc_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared codes for the multi-cycle MIPS main controller: control-field
// encodings, Op/Funct constants, FSM states and decoded instruction classes.
package mc_ctrl_pkg;

  // Immediate extender modes
  localparam logic [1:0] EXT_UNSIGNED = 2'b00;
  localparam logic [1:0] EXT_SIGNED   = 2'b01;
  localparam logic [1:0] EXT_POS_H    = 2'b10;

  // ALU operations
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_OR     = 3'b010;
  localparam logic [2:0] ALU_SLT    = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;

  // Next-PC source
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_RS  = 2'b11;

  // Register-file write data source
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MDR = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  // Register-file destination
  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE = 4'd0,
    C_JR    = 4'd1,
    C_IMM   = 4'd2,
    C_LW    = 4'd3,
    C_SW    = 4'd4,
    C_BEQ   = 4'd5,
    C_J     = 4'd6,
    C_JAL   = 4'd7,
    C_ILL   = 4'd8
  } iclass_e;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and Zero flag towards the
// controller, control strobes and selects back to the datapath.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWr;
  logic       IRWr;
  logic       RegWr;
  logic       MemWr;
  logic [1:0] EXTSel;
  logic [2:0] ALUOp;
  logic       ALUSrcB;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic [1:0] NPCSel;
  logic       Illegal;

  // Datapath side
  modport master (
    output Op, Funct, Zero,
    input  PCWr, IRWr, RegWr, MemWr, EXTSel, ALUOp, ALUSrcB,
           RegDst, WDSel, NPCSel, Illegal
  );

  // Controller side
  modport slave (
    input  Op, Funct, Zero,
    output PCWr, IRWr, RegWr, MemWr, EXTSel, ALUOp, ALUSrcB,
           RegDst, WDSel, NPCSel, Illegal
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decode: Op/Funct to instruction class plus the
// state-independent controls (extender mode, ALU operation, ALU B source).
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic [1:0] extsel_o,
  output logic [2:0] aluop_o,
  output logic       alusrcb_o
);

  // Unsupported encodings fall out as C_ILL with sign extension and ADD
  always_comb begin
    iclass_o  = C_ILL;
    extsel_o  = EXT_SIGNED;
    aluop_o   = ALU_ADD;
    alusrcb_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: iclass_o = C_RTYPE;
          FN_SUBU: begin iclass_o = C_RTYPE; aluop_o = ALU_SUB; end
          FN_SLT:  begin iclass_o = C_RTYPE; aluop_o = ALU_SLT; end
          FN_JR:   iclass_o = C_JR;
          default: iclass_o = C_ILL;
        endcase
      end
      OP_ORI:   begin iclass_o = C_IMM; extsel_o = EXT_UNSIGNED; aluop_o = ALU_OR; alusrcb_o = 1'b1; end
      OP_LUI:   begin iclass_o = C_IMM; extsel_o = EXT_POS_H; aluop_o = ALU_PASS_B; alusrcb_o = 1'b1; end
      OP_ADDIU: begin iclass_o = C_IMM; alusrcb_o = 1'b1; end
      OP_LW:    begin iclass_o = C_LW;  alusrcb_o = 1'b1; end
      OP_SW:    begin iclass_o = C_SW;  alusrcb_o = 1'b1; end
      OP_BEQ:   begin iclass_o = C_BEQ; aluop_o = ALU_SUB; end
      OP_J:     iclass_o = C_J;
      OP_JAL:   iclass_o = C_JAL;
      default:  iclass_o = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: IF/ID/EXE/MEM/WB sequencer with a
// wait counter that stretches IF and MEM by MEM_WAIT cycles.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.slave   bus
);

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  iclass_e    iclass;
  logic       wait_done;
  logic       pcwr, irwr, regwr, memwr, illegal;
  logic [1:0] npcsel, regdst, wdsel;

  mc_decode u_decode (
    .op_i      (bus.Op),
    .funct_i   (bus.Funct),
    .iclass_o  (iclass),
    .extsel_o  (bus.EXTSel),
    .aluop_o   (bus.ALUOp),
    .alusrcb_o (bus.ALUSrcB)
  );

  assign wait_done = (cnt_q == WAIT_MAX);

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore control outputs; counter clears whenever it is not counting
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pcwr    = 1'b0;
    irwr    = 1'b0;
    regwr   = 1'b0;
    memwr   = 1'b0;
    illegal = 1'b0;
    npcsel  = NPC_PC4;
    regdst  = (iclass == C_RTYPE) ? RD_RD  : (iclass == C_JAL) ? RD_R31 : RD_RT;
    wdsel   = (iclass == C_LW)    ? WD_MDR : (iclass == C_JAL) ? WD_PC  : WD_ALU;
    case (state_q)
      S_IF: begin
        if (wait_done) begin
          pcwr    = 1'b1;
          irwr    = 1'b1;
          state_d = S_ID;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ID: begin
        case (iclass)
          C_J:     begin pcwr = 1'b1; npcsel = NPC_J; state_d = S_IF; end
          C_JAL:   begin pcwr = 1'b1; regwr = 1'b1; npcsel = NPC_J; state_d = S_IF; end
          C_JR:    begin pcwr = 1'b1; npcsel = NPC_RS; state_d = S_IF; end
          C_ILL:   begin illegal = 1'b1; state_d = S_IF; end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (iclass)
          C_BEQ:      begin pcwr = bus.Zero; npcsel = NPC_BR; state_d = S_IF; end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (wait_done) begin
          if (iclass == C_SW) begin
            memwr   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WB: begin
        regwr   = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Write enables and Illegal are forced low in any cycle rst is asserted
  assign bus.PCWr    = pcwr    & ~rst;
  assign bus.IRWr    = irwr    & ~rst;
  assign bus.RegWr   = regwr   & ~rst;
  assign bus.MemWr   = memwr   & ~rst;
  assign bus.Illegal = illegal & ~rst;
  assign bus.NPCSel  = npcsel;
  assign bus.RegDst  = regdst;
  assign bus.WDSel   = wdsel;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: two instances (MEM_WAIT=0 and MEM_WAIT=2) share clk/rst.
// Per-cycle expected control vectors are pushed to a queue per instance when
// an instruction is launched and popped/compared on each falling edge.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  typedef enum int {K_R, K_IMM, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_e;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    kind_e      kind;
    logic [2:0] aluop;
    logic       srcb;
    logic [1:0] ext;
    logic [1:0] rd;
    logic [1:0] wd;
  } ins_t;

  typedef struct packed {
    logic [16:0] v;
    logic [16:0] m;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q0[$];
  exp_t q2[$];

  mc_ctrl_if b0();
  mc_ctrl_if b2();

  mc_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mc_ctrl #(.MEM_WAIT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  logic [16:0] a0, a2;
  assign a0 = {b0.PCWr, b0.IRWr, b0.RegWr, b0.MemWr, b0.Illegal, b0.EXTSel,
               b0.NPCSel, b0.RegDst, b0.WDSel, b0.ALUOp, b0.ALUSrcB};
  assign a2 = {b2.PCWr, b2.IRWr, b2.RegWr, b2.MemWr, b2.Illegal, b2.EXTSel,
               b2.NPCSel, b2.RegDst, b2.WDSel, b2.ALUOp, b2.ALUSrcB};

  localparam logic [16:0] M_WR = 17'h1F000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] pk(input logic pcwr, irwr, regwr, memwr, ill,
                                     input logic [1:0] ext, npc, rd, wd,
                                     input logic [2:0] alu, input logic srcb);
    return {pcwr, irwr, regwr, memwr, ill, ext, npc, rd, wd, alu, srcb};
  endfunction

  function automatic ins_t mk(string n, logic [5:0] op, logic [5:0] fn, kind_e k,
                              logic [2:0] alu, logic srcb, logic [1:0] ext,
                              logic [1:0] rd, logic [1:0] wd);
    ins_t r;
    r.name = n; r.op = op; r.funct = fn; r.kind = k; r.aluop = alu;
    r.srcb = srcb; r.ext = ext; r.rd = rd; r.wd = wd;
    return r;
  endfunction

  task automatic put(input bit sel2, input logic [16:0] v, input logic [16:0] m);
    exp_t e;
    e.v = v;
    e.m = m;
    if (sel2) q2.push_back(e);
    else      q0.push_back(e);
  endtask

  // Expected per-cycle controls for one instruction on an instance with wait w
  task automatic push_trace(input ins_t in, input logic zero, input int w,
                            input bit add_next, input bit sel2);
    bit last;
    bit done;
    done = 1'b0;
    for (int c = 0; c <= w; c++) begin
      last = (c == w);
      put(sel2, pk(last, last, 0, 0, 0, in.ext, NPC_PC4, 2'b00, 2'b00, 3'b000, 0),
                pk(1, 1, 1, 1, 1, 2'b11, last ? 2'b11 : 2'b00, 2'b00, 2'b00, 3'b000, 0));
    end
    case (in.kind)
      K_J: begin
        put(sel2, pk(1, 0, 0, 0, 0, in.ext, NPC_J, 2'b00, 2'b00, 3'b000, 0),
                  pk(1, 1, 1, 1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 0));
        done = 1'b1;
      end
      K_JAL: begin
        put(sel2, pk(1, 0, 1, 0, 0, in.ext, NPC_J, RD_R31, WD_PC, 3'b000, 0),
                  pk(1, 1, 1, 1, 1, 2'b11, 2'b11, 2'b11, 2'b11, 3'b000, 0));
        done = 1'b1;
      end
      K_JR: begin
        put(sel2, pk(1, 0, 0, 0, 0, in.ext, NPC_RS, 2'b00, 2'b00, 3'b000, 0),
                  pk(1, 1, 1, 1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 0));
        done = 1'b1;
      end
      K_ILL: begin
        put(sel2, pk(0, 0, 0, 0, 1, in.ext, 2'b00, 2'b00, 2'b00, 3'b000, 0),
                  pk(1, 1, 1, 1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        done = 1'b1;
      end
      default: begin
        put(sel2, pk(0, 0, 0, 0, 0, in.ext, 2'b00, 2'b00, 2'b00, 3'b000, 0),
                  pk(1, 1, 1, 1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      end
    endcase
    if (!done) begin
      if (in.kind == K_BEQ) begin
        put(sel2, pk(zero, 0, 0, 0, 0, in.ext, NPC_BR, 2'b00, 2'b00, in.aluop, in.srcb),
                  pk(1, 1, 1, 1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 3'b111, 1));
        done = 1'b1;
      end else begin
        put(sel2, pk(0, 0, 0, 0, 0, in.ext, 2'b00, 2'b00, 2'b00, in.aluop, in.srcb),
                  pk(1, 1, 1, 1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b111, 1));
      end
    end
    if (!done && (in.kind == K_LW || in.kind == K_SW)) begin
      for (int c = 0; c <= w; c++) begin
        last = (c == w);
        put(sel2, pk(0, 0, 0, (in.kind == K_SW) && last, 0, in.ext, 2'b00, 2'b00, 2'b00, 3'b000, 0),
                  pk(1, 1, 1, 1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      end
      if (in.kind == K_SW) done = 1'b1;
    end
    if (!done) begin
      put(sel2, pk(0, 0, 1, 0, 0, in.ext, 2'b00, in.rd, in.wd, in.aluop, in.srcb),
                pk(1, 1, 1, 1, 1, 2'b11, 2'b00, 2'b11, 2'b11, 3'b111, 1));
    end
    if (add_next) begin
      put(sel2, pk(w == 0, w == 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), M_WR);
    end
  endtask

  task automatic set_ins(input ins_t in, input logic zero);
    b0.Op = in.op; b0.Funct = in.funct; b0.Zero = zero;
    b2.Op = in.op; b2.Funct = in.funct; b2.Zero = zero;
  endtask

  // Write enables and Illegal stay low while rst is held, even for jal / illegal Op
  task automatic test_reset();
    exp_t e;
    q0.delete(); q2.delete();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b0.Op = (k == 0) ? 6'h3F : OP_JAL; b0.Funct = 6'h00; b0.Zero = 1'b1;
      b2.Op = b0.Op; b2.Funct = 6'h00; b2.Zero = 1'b1;
      put(0, 17'd0, M_WR);
      put(1, 17'd0, M_WR);
      @(negedge clk);
      e = q0.pop_front(); total++;
      if (((a0 ^ e.v) & e.m) !== 17'd0) begin
        bad++; $display("FAIL reset_w0 cyc=%0d actual=%05h required=%05h mask=%05h", k, a0, e.v, e.m);
      end
      e = q2.pop_front(); total++;
      if (((a2 ^ e.v) & e.m) !== 17'd0) begin
        bad++; $display("FAIL reset_w2 cyc=%0d actual=%05h required=%05h mask=%05h", k, a2, e.v, e.m);
      end
      @(posedge clk); #1;
    end
  endtask

  // One instruction from a fresh reset on both instances, plus the following IF cycle
  task automatic test_instr(input ins_t in, input logic zero);
    exp_t e;
    int n;
    q0.delete(); q2.delete();
    push_trace(in, zero, 0, 1, 0);
    push_trace(in, zero, 2, 1, 1);
    n = (q0.size() > q2.size()) ? q0.size() : q2.size();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_ins(in, zero);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front(); total++;
        if (((a0 ^ e.v) & e.m) !== 17'd0) begin
          bad++; $display("FAIL %s_w0 cyc=%0d actual=%05h required=%05h mask=%05h", in.name, k, a0, e.v, e.m);
        end
      end
      if (q2.size() > 0) begin
        e = q2.pop_front(); total++;
        if (((a2 ^ e.v) & e.m) !== 17'd0) begin
          bad++; $display("FAIL %s_w2 cyc=%0d actual=%05h required=%05h mask=%05h", in.name, k, a2, e.v, e.m);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // rst held two cycles in MEM of lw (MEM_WAIT=2): no write, full IF wait afterwards
  task automatic test_reset_mid_lw(input ins_t in);
    exp_t e;
    q0.delete(); q2.delete();
    push_trace(in, 1'b0, 2, 0, 1);
    while (q2.size() > 5) void'(q2.pop_back());
    put(1, 17'd0, M_WR);
    put(1, 17'd0, M_WR);
    put(1, 17'd0, M_WR);
    put(1, 17'd0, M_WR);
    put(1, pk(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), M_WR);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_ins(in, 1'b0);
    for (int k = 0; k < 10; k++) begin
      rst = (k == 5 || k == 6);
      @(negedge clk);
      e = q2.pop_front(); total++;
      if (((a2 ^ e.v) & e.m) !== 17'd0) begin
        bad++; $display("FAIL lw_mem_reset cyc=%0d actual=%05h required=%05h mask=%05h", k, a2, e.v, e.m);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  // Instruction stream without reset on the MEM_WAIT=0 instance
  task automatic test_back_to_back(input ins_t seq[6], input logic zs[6]);
    exp_t e;
    int n;
    q0.delete(); q2.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_trace(seq[i], zs[i], 0, 0, 0);
      n = q0.size();
      set_ins(seq[i], zs[i]);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        e = q0.pop_front(); total++;
        if (((a0 ^ e.v) & e.m) !== 17'd0) begin
          bad++; $display("FAIL b2b_%s cyc=%0d actual=%05h required=%05h mask=%05h", seq[i].name, k, a0, e.v, e.m);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    ins_t i_addu, i_subu, i_slt, i_jr, i_ori, i_lui, i_addiu, i_lw, i_sw;
    ins_t i_beq, i_j, i_jal, i_badop, i_badfn;
    ins_t seq[6];
    logic zs[6];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    b0.Op = 6'h00; b0.Funct = 6'h00; b0.Zero = 1'b0;
    b2.Op = 6'h00; b2.Funct = 6'h00; b2.Zero = 1'b0;

    i_addu  = mk("addu",  6'h00, 6'h21, K_R,   3'b000, 0, EXT_SIGNED,   2'b01, 2'b00);
    i_subu  = mk("subu",  6'h00, 6'h23, K_R,   3'b001, 0, EXT_SIGNED,   2'b01, 2'b00);
    i_slt   = mk("slt",   6'h00, 6'h2A, K_R,   3'b011, 0, EXT_SIGNED,   2'b01, 2'b00);
    i_jr    = mk("jr",    6'h00, 6'h08, K_JR,  3'b000, 0, EXT_SIGNED,   2'b00, 2'b00);
    i_ori   = mk("ori",   6'h0D, 6'h15, K_IMM, 3'b010, 1, EXT_UNSIGNED, 2'b00, 2'b00);
    i_lui   = mk("lui",   6'h0F, 6'h00, K_IMM, 3'b100, 1, EXT_POS_H,    2'b00, 2'b00);
    i_addiu = mk("addiu", 6'h09, 6'h3C, K_IMM, 3'b000, 1, EXT_SIGNED,   2'b00, 2'b00);
    i_lw    = mk("lw",    6'h23, 6'h04, K_LW,  3'b000, 1, EXT_SIGNED,   2'b00, 2'b01);
    i_sw    = mk("sw",    6'h2B, 6'h08, K_SW,  3'b000, 1, EXT_SIGNED,   2'b00, 2'b00);
    i_beq   = mk("beq",   6'h04, 6'h02, K_BEQ, 3'b001, 0, EXT_SIGNED,   2'b00, 2'b00);
    i_j     = mk("j",     6'h02, 6'h00, K_J,   3'b000, 0, EXT_SIGNED,   2'b00, 2'b00);
    i_jal   = mk("jal",   6'h03, 6'h00, K_JAL, 3'b000, 0, EXT_SIGNED,   2'b10, 2'b10);
    i_badop = mk("badop", 6'h3F, 6'h00, K_ILL, 3'b000, 0, EXT_SIGNED,   2'b00, 2'b00);
    i_badfn = mk("badfn", 6'h00, 6'h20, K_ILL, 3'b000, 0, EXT_SIGNED,   2'b00, 2'b00);

    @(posedge clk); #1;
    test_reset();
    test_instr(i_addu, 1'b0);
    test_instr(i_subu, 1'b0);
    test_instr(i_slt, 1'b0);
    test_instr(i_jr, 1'b0);
    test_instr(i_ori, 1'b0);
    test_instr(i_lui, 1'b0);
    test_instr(i_addiu, 1'b0);
    test_instr(i_lw, 1'b0);
    test_instr(i_sw, 1'b1);
    test_instr(i_beq, 1'b1);
    test_instr(i_beq, 1'b0);
    test_instr(i_j, 1'b0);
    test_instr(i_jal, 1'b0);
    test_instr(i_badop, 1'b0);
    test_instr(i_badfn, 1'b0);
    test_reset_mid_lw(i_lw);

    seq[0] = i_addu; zs[0] = 1'b0;
    seq[1] = i_sw;   zs[1] = 1'b0;
    seq[2] = i_beq;  zs[2] = 1'b1;
    seq[3] = i_lui;  zs[3] = 1'b0;
    seq[4] = i_jal;  zs[4] = 1'b0;
    seq[5] = i_lw;   zs[5] = 1'b1;
    test_back_to_back(seq, zs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
